// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, captures the instruction memory word into IF/ID,
// and handles stall, branch/jump redirect with flush, misaligned-target faulting and fetch count.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_INC    = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] InstructionCode,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        MisalignFault,
  output logic [31:0] FetchCount
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_pc_plus4;
  logic        r_if_id_valid;
  logic        r_misalign_fault;
  logic [31:0] r_fetch_count;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_seq;

  // Branch outranks jump when both resolve in the same cycle.
  assign w_redirect = BranchTaken | Jump;
  assign w_target   = BranchTaken ? BranchTarget : JumpTarget;
  assign w_pc_seq   = r_pc + PC_INC;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc             <= RESET_PC;
      r_if_id_instr    <= NOP_INSTR;
      r_if_id_pc       <= 32'h0;
      r_if_id_pc_plus4 <= 32'h0;
      r_if_id_valid    <= 1'b0;
      r_misalign_fault <= 1'b0;
      r_fetch_count    <= 32'h0;
    end else if (w_redirect) begin
      // Redirect beats stall; the word fetched this cycle is on the wrong path and is dropped.
      r_pc             <= {w_target[31:2], 2'b00};
      r_if_id_instr    <= NOP_INSTR;
      r_if_id_pc       <= 32'h0;
      r_if_id_pc_plus4 <= 32'h0;
      r_if_id_valid    <= 1'b0;
      if (w_target[1:0] != 2'b00) begin
        r_misalign_fault <= 1'b1;
      end
    end else if (!Stall) begin
      r_pc             <= w_pc_seq;
      r_if_id_instr    <= InstructionCode;
      r_if_id_pc       <= r_pc;
      r_if_id_pc_plus4 <= w_pc_seq;
      r_if_id_valid    <= 1'b1;
      r_fetch_count    <= r_fetch_count + 32'd1;
    end
  end

  assign PC            = r_pc;
  assign IF_ID_Instr   = r_if_id_instr;
  assign IF_ID_PC      = r_if_id_pc;
  assign IF_ID_PCPlus4 = r_if_id_pc_plus4;
  assign IF_ID_Valid   = r_if_id_valid;
  assign MisalignFault = r_misalign_fault;
  assign FetchCount    = r_fetch_count;

endmodule
